// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_pkg
//  Description : Shared widths, default geometry and note entry type for the
//                falling-note display engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_pkg;

    localparam int CMD_W        = 4;
    localparam int NOTE_Y_W     = 10;

    localparam int DEF_LANES     = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_X_W       = 10;
    localparam int DEF_Y_W       = NOTE_Y_W;
    localparam int DEF_X0        = 160;
    localparam int DEF_LANE_W    = 80;
    localparam int DEF_NOTE_H    = 16;
    localparam int DEF_SPEED     = 4;
    localparam int DEF_Y_INIT    = 0;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_HIT_Y_MIN = 440;
    localparam int DEF_HIT_Y_MAX = 463;

    typedef struct packed {
        logic [NOTE_Y_W-1:0] y;
        logic [CMD_W-1:0]    cmd;
    } note_t;

    // Index width for a lane selector; a single lane still needs one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_lane.sv
`default_nettype none
// ============================================================================
//  Module      : note_lane
//  Description : One lane of falling notes: in-order circular buffer with
//                advance, retire, hit-pop, spawn and oldest-match lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_lane
    import note_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = $clog2(DEF_DEPTH) + 1,
    parameter int NOTE_H    = DEF_NOTE_H,
    parameter int SPEED     = DEF_SPEED,
    parameter int Y_INIT    = DEF_Y_INIT,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int HIT_Y_MIN = DEF_HIT_Y_MIN,
    parameter int HIT_Y_MAX = DEF_HIT_Y_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_frame_tick,
    input  logic                i_spawn_en,
    input  logic [CMD_W-1:0]    i_spawn_cmd,
    input  logic                i_hit_en,
    input  logic [NOTE_Y_W-1:0] i_next_y,
    output logic                o_spawn_ready,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_hit_pop,
    output logic                o_hit_bad,
    output logic                o_retire,
    output logic                o_match,
    output logic [CMD_W-1:0]    o_match_cmd
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    note_t                r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [CNT_W-1:0]     r_count;

    note_t                w_head_note;
    logic [NOTE_Y_W:0]    w_head_adv;
    logic                 w_empty;
    logic                 w_ready;
    logic                 w_in_window;
    logic                 w_hit_pop;
    logic                 w_retire;
    logic                 w_pop;
    logic                 w_push;

    logic                 w_found;
    logic [CMD_W-1:0]     w_found_cmd;
    logic [c_ptr_w-1:0]   w_slot;
    note_t                w_note;
    logic [NOTE_Y_W:0]    w_y_bot;

    assign w_head_note = r_mem[r_head];
    assign w_head_adv  = {1'b0, w_head_note.y} + (NOTE_Y_W+1)'(SPEED);
    assign w_empty     = (r_count == '0);
    assign w_ready     = (r_count != CNT_W'(DEPTH));
    assign w_in_window = (w_head_note.y >= NOTE_Y_W'(HIT_Y_MIN)) &&
                         (w_head_note.y <= NOTE_Y_W'(HIT_Y_MAX));
    assign w_hit_pop   = i_hit_en && !w_empty && w_in_window;
    // A strike that pops the head pre-empts the retire check on the same tick.
    assign w_retire    = i_frame_tick && !w_empty && !w_hit_pop &&
                         (w_head_adv >= (NOTE_Y_W+1)'(SCREEN_H));
    assign w_pop       = w_hit_pop || w_retire;
    assign w_push      = i_spawn_en && w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots counted by r_count are ever observed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (w_push && (r_tail == c_ptr_w'(k))) begin
                r_mem[k].y   <= NOTE_Y_W'(Y_INIT);
                r_mem[k].cmd <= i_spawn_cmd;
            end else if (i_frame_tick) begin
                r_mem[k].y   <= r_mem[k].y + NOTE_Y_W'(SPEED);
            end
        end
    end

    always_comb begin
        w_found     = 1'b0;
        w_found_cmd = '0;
        w_slot      = r_head;
        w_note      = r_mem[r_head];
        w_y_bot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot  = r_head + c_ptr_w'(k);
            w_note  = r_mem[w_slot];
            w_y_bot = {1'b0, w_note.y} + (NOTE_Y_W+1)'(NOTE_H);
            if (!w_found && (CNT_W'(k) < r_count) &&
                (i_next_y >= w_note.y) && ({1'b0, i_next_y} < w_y_bot)) begin
                w_found     = 1'b1;
                w_found_cmd = w_note.cmd;
            end
        end
    end

    assign o_spawn_ready = w_ready;
    assign o_count       = r_count;
    assign o_hit_pop     = w_hit_pop;
    assign o_hit_bad     = i_hit_en && !w_hit_pop;
    assign o_retire      = w_retire;
    assign o_match       = w_found;
    assign o_match_cmd   = w_found_cmd;

endmodule
`default_nettype wire

// File: rtl/note_lane_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : note_lane_scroller
//  Description : Multi-lane falling-note engine: lane decode of the requested
//                pixel, registered colour lookup and hit/miss pulse outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_lane_scroller
    import note_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int X0        = DEF_X0,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int NOTE_H    = DEF_NOTE_H,
    parameter int SPEED     = DEF_SPEED,
    parameter int Y_INIT    = DEF_Y_INIT,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int HIT_Y_MIN = DEF_HIT_Y_MIN,
    parameter int HIT_Y_MAX = DEF_HIT_Y_MAX
) (
    input  logic                         CLOCK_25,
    input  logic                         reset_n,
    input  logic                         frame_tick,
    input  logic                         spawn_valid,
    input  logic [lane_idx_w(LANES)-1:0] spawn_lane,
    input  logic [CMD_W-1:0]             spawn_cmd,
    output logic [LANES-1:0]             spawn_ready,
    input  logic                         hit_valid,
    input  logic [lane_idx_w(LANES)-1:0] hit_lane,
    input  logic [X_W-1:0]               next_x,
    input  logic [Y_W-1:0]               next_y,
    output logic                         pixel_on,
    output logic [CMD_W-1:0]             command_out,
    output logic                         hit_ok,
    output logic                         hit_bad,
    output logic [LANES-1:0]             miss_vec,
    output logic [LANES*4-1:0]           note_count
);

    localparam int c_lw    = lane_idx_w(LANES);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [LANES-1:0]   w_in_lane;
    logic [LANES-1:0]   w_spawn_en;
    logic [LANES-1:0]   w_hit_en;
    logic [LANES-1:0]   w_hit_pop;
    logic [LANES-1:0]   w_hit_bad;
    logic [LANES-1:0]   w_retire;
    logic [LANES-1:0]   w_match;
    logic [CMD_W-1:0]   w_match_cmd [LANES];
    logic [c_cnt_w-1:0] w_count     [LANES];

    logic               w_pix_on;
    logic [CMD_W-1:0]   w_pix_cmd;

    logic               r_pixel_on;
    logic [CMD_W-1:0]   r_command;
    logic               r_hit_ok;
    logic               r_hit_bad;
    logic [LANES-1:0]   r_miss;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [X_W+1:0]  c_x_lo     = (X_W+2)'(X0 + i * LANE_W);
            localparam logic [X_W+1:0]  c_x_hi     = (X_W+2)'(X0 + (i + 1) * LANE_W);
            localparam logic [c_lw-1:0] c_lane_idx = c_lw'(i);

            // Lanes are contiguous slabs of x; two compares replace a divider.
            assign w_in_lane[i]  = ({2'b00, next_x} >= c_x_lo) &&
                                   ({2'b00, next_x} <  c_x_hi);
            assign w_spawn_en[i] = spawn_valid && (spawn_lane == c_lane_idx);
            assign w_hit_en[i]   = hit_valid && (hit_lane == c_lane_idx);

            note_lane #(
                .DEPTH     (DEPTH),
                .CNT_W     (c_cnt_w),
                .NOTE_H    (NOTE_H),
                .SPEED     (SPEED),
                .Y_INIT    (Y_INIT),
                .SCREEN_H  (SCREEN_H),
                .HIT_Y_MIN (HIT_Y_MIN),
                .HIT_Y_MAX (HIT_Y_MAX)
            ) u_lane (
                .clk           (CLOCK_25),
                .reset_n       (reset_n),
                .i_frame_tick  (frame_tick),
                .i_spawn_en    (w_spawn_en[i]),
                .i_spawn_cmd   (spawn_cmd),
                .i_hit_en      (w_hit_en[i]),
                .i_next_y      (next_y),
                .o_spawn_ready (spawn_ready[i]),
                .o_count       (w_count[i]),
                .o_hit_pop     (w_hit_pop[i]),
                .o_hit_bad     (w_hit_bad[i]),
                .o_retire      (w_retire[i]),
                .o_match       (w_match[i]),
                .o_match_cmd   (w_match_cmd[i])
            );

            assign note_count[i*4 +: 4] = 4'(w_count[i]);
        end
    endgenerate

    always_comb begin
        w_pix_on  = 1'b0;
        w_pix_cmd = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_in_lane[i] && w_match[i]) begin
                w_pix_on  = 1'b1;
                w_pix_cmd = w_match_cmd[i];
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_on <= 1'b0;
            r_command  <= '0;
            r_hit_ok   <= 1'b0;
            r_hit_bad  <= 1'b0;
            r_miss     <= '0;
        end else begin
            r_pixel_on <= w_pix_on;
            r_command  <= w_pix_cmd;
            r_hit_ok   <= |w_hit_pop;
            r_hit_bad  <= |w_hit_bad;
            r_miss     <= w_retire;
        end
    end

    assign pixel_on    = r_pixel_on;
    assign command_out = r_command;
    assign hit_ok      = r_hit_ok;
    assign hit_bad     = r_hit_bad;
    assign miss_vec    = r_miss;

endmodule
`default_nettype wire
